// File: rtl/uart_irq_ctrl.sv
// UART interrupt controller: per-source edge detect and sticky status, W1C/W1S access,
// rx_done coalescing by count threshold and idle timeout, registered irq line.

module uart_irq_cell (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic evt,
  input  logic hit,
  input  logic clr,
  input  logic set,
  output logic rise,
  output logic status
);
  logic evt_q;

  assign rise = evt & ~evt_q;

  // hit/set are OR-ed after the clear so a same-cycle event always survives a W1C
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      evt_q  <= 1'b0;
      status <= 1'b0;
    end else begin
      evt_q  <= evt;
      status <= (status & ~clr) | hit | set;
    end
  end
endmodule

module uart_irq_ctrl #(
  parameter int NUM_SRC = 9,
  parameter int CNT_W   = 8,
  parameter int TMO_W   = 16
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic [NUM_SRC-1:0] evt_i,
  input  logic [NUM_SRC-1:0] enable_i,
  input  logic               clr_we_i,
  input  logic [NUM_SRC-1:0] clr_data_i,
  input  logic               set_we_i,
  input  logic [NUM_SRC-1:0] set_data_i,
  input  logic [CNT_W-1:0]   rx_thresh_i,
  input  logic [TMO_W-1:0]   rx_timeout_i,
  output logic [NUM_SRC-1:0] status_o,
  output logic [NUM_SRC-1:0] pending_o,
  output logic               irq_o,
  output logic [CNT_W-1:0]   rx_cnt_o
);
  localparam int RX_BIT = 1;

  typedef enum logic {IDLE, ACCUM} state_e;

  state_e             state;
  logic [CNT_W-1:0]   cnt;
  logic [TMO_W-1:0]   timer;
  logic [NUM_SRC-1:0] rise, hit, clr_mask, set_mask;
  logic [CNT_W-1:0]   cnt_sat;
  logic               thr_inc, thr_now, tmo_hit, fire;

  assign clr_mask = clr_we_i ? clr_data_i : '0;
  assign set_mask = set_we_i ? set_data_i : '0;

  // rx_done feeds status through the coalescer; every other source is a raw rising edge
  always_comb begin
    hit         = rise;
    hit[RX_BIT] = fire;
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    uart_irq_cell u_cell (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .evt    (evt_i[g]),
      .hit    (hit[g]),
      .clr    (clr_mask[g]),
      .set    (set_mask[g]),
      .rise   (rise[g]),
      .status (status_o[g])
    );
  end

  assign cnt_sat = (&cnt) ? cnt : cnt + CNT_W'(1);
  assign thr_inc = cnt_sat >= rx_thresh_i;
  assign thr_now = cnt >= rx_thresh_i;
  assign tmo_hit = (rx_timeout_i != '0) && (timer == rx_timeout_i - TMO_W'(1));

  // Combinational fire so the status bit lands on the same edge as the triggering pulse.
  // In IDLE cnt is 0, so thr_inc reduces to "1 >= threshold", which also covers bypass.
  always_comb begin
    fire = 1'b0;
    case (state)
      IDLE:    fire = rise[RX_BIT] & thr_inc;
      ACCUM:   fire = rise[RX_BIT] ? thr_inc : (thr_now | tmo_hit);
      default: fire = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      cnt   <= '0;
      timer <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (rise[RX_BIT] && !fire) begin
            cnt   <= CNT_W'(1);
            timer <= '0;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (fire) begin
            cnt   <= '0;
            timer <= '0;
            state <= IDLE;
          end else if (rise[RX_BIT]) begin
            cnt   <= cnt_sat;
            timer <= '0;
          end else if (!(&timer)) begin
            timer <= timer + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) irq_o <= 1'b0;
    else         irq_o <= |(status_o & enable_i);
  end

  assign pending_o = status_o & enable_i;
  assign rx_cnt_o  = cnt;
endmodule

// File: tb/tb_uart_irq_ctrl.sv
// Bench for uart_irq_ctrl: directed steps plus randomized traffic, checked every cycle
// against an integer-arithmetic model of status, coalescing count and irq.

module tb_uart_irq_ctrl;
  logic       clk_i = 1'b0;
  logic       rstn_i;
  logic [8:0] evt_i, enable_i, clr_data_i, set_data_i;
  logic       clr_we_i, set_we_i;
  logic [7:0] rx_thresh_i;
  logic [15:0] rx_timeout_i;
  logic [8:0] status_o, pending_o;
  logic       irq_o;
  logic [7:0] rx_cnt_o;

  int vectors = 0;
  int miscompares = 0;

  // model state
  logic [8:0] m_status, m_prev;
  logic       m_irq;
  int         m_cnt, m_idle;

  uart_irq_ctrl dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .evt_i        (evt_i),
    .enable_i     (enable_i),
    .clr_we_i     (clr_we_i),
    .clr_data_i   (clr_data_i),
    .set_we_i     (set_we_i),
    .set_data_i   (set_data_i),
    .rx_thresh_i  (rx_thresh_i),
    .rx_timeout_i (rx_timeout_i),
    .status_o     (status_o),
    .pending_o    (pending_o),
    .irq_o        (irq_o),
    .rx_cnt_o     (rx_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_status = '0; m_prev = '0; m_irq = 1'b0; m_cnt = 0; m_idle = 0;
  endtask

  // Advance one clock: the model consumes the current inputs, then outputs are compared.
  task automatic tick();
    logic [8:0] rise, hit, clr, set;
    logic fire;
    int n, thr, tmo;
    thr  = int'(rx_thresh_i);
    tmo  = int'(rx_timeout_i);
    rise = evt_i & ~m_prev;
    fire = 1'b0;
    if (rise[1]) begin
      n = (m_cnt < 255) ? m_cnt + 1 : 255;
      if (n >= thr) begin fire = 1'b1; m_cnt = 0; end
      else m_cnt = n;
      m_idle = 0;
    end else if (m_cnt > 0) begin
      if (m_cnt >= thr || (tmo != 0 && m_idle == tmo - 1)) begin
        fire = 1'b1; m_cnt = 0; m_idle = 0;
      end else if (m_idle < 65535) m_idle++;
    end
    hit    = rise;
    hit[1] = fire;
    clr    = clr_we_i ? clr_data_i : '0;
    set    = set_we_i ? set_data_i : '0;
    m_irq    = |(m_status & enable_i);
    m_status = (m_status & ~clr) | hit | set;
    m_prev   = evt_i;
    @(posedge clk_i); #1;
    chk("status", 32'(status_o), 32'(m_status));
    chk("pending", 32'(pending_o), 32'(m_status & enable_i));
    chk("irq", 32'(irq_o), 32'(m_irq));
    chk("rx_cnt", 32'(rx_cnt_o), 32'(m_cnt));
  endtask

  task automatic clear_all();
    evt_i = '0; enable_i = '0; set_we_i = 1'b0;
    clr_we_i = 1'b1; clr_data_i = '1;
    tick();
    clr_we_i = 1'b0; clr_data_i = '0;
    tick();
  endtask

  initial begin
    rstn_i = 1'b0;
    evt_i = 9'h008; enable_i = '0;
    clr_we_i = 1'b0; clr_data_i = '0; set_we_i = 1'b0; set_data_i = '0;
    rx_thresh_i = '0; rx_timeout_i = '0;
    model_reset();
    #12;
    chk("reset_status", 32'(status_o), 32'h0);
    chk("reset_irq", 32'(irq_o), 32'h0);
    chk("reset_rx_cnt", 32'(rx_cnt_o), 32'h0);
    rstn_i = 1'b1;

    // source high at reset release counts as an event; masked, so no irq
    tick();
    chk("rel_status", 32'(status_o), 32'h008);
    tick();
    chk("rel_irq_masked", 32'(irq_o), 32'h0);
    enable_i = 9'h008;
    tick();
    chk("unmask_irq", 32'(irq_o), 32'h1);
    clear_all();

    // single pulse on bit 7, then W1C
    enable_i = 9'h080; evt_i = 9'h080;
    tick();
    chk("p7_status", 32'(status_o[7]), 32'h1);
    chk("p7_irq_lat", 32'(irq_o), 32'h0);
    evt_i = '0;
    tick();
    chk("p7_irq", 32'(irq_o), 32'h1);
    clr_we_i = 1'b1; clr_data_i = 9'h080;
    tick();
    chk("w1c_status", 32'(status_o[7]), 32'h0);
    chk("w1c_irq_lat", 32'(irq_o), 32'h1);
    clr_we_i = 1'b0; clr_data_i = '0;
    tick();
    chk("w1c_irq", 32'(irq_o), 32'h0);

    // event and clear in the same cycle: event wins
    evt_i = 9'h040; clr_we_i = 1'b1; clr_data_i = 9'h040;
    tick();
    chk("evt_vs_clr", 32'(status_o[6]), 32'h1);
    clear_all();

    // count threshold 4, no timeout
    rx_thresh_i = 8'd4; rx_timeout_i = '0;
    for (int p = 0; p < 4; p++) begin
      evt_i = 9'h002;
      tick();
      if (p < 3) begin
        chk("thr_cnt", 32'(rx_cnt_o), 32'(p + 1));
        chk("thr_no_fire", 32'(status_o[1]), 32'h0);
      end else begin
        chk("thr_fire", 32'(status_o[1]), 32'h1);
        chk("thr_cnt0", 32'(rx_cnt_o), 32'h0);
      end
      evt_i = '0;
      for (int i = 0; i < 9; i++) tick();
    end
    clear_all();

    // timeout 20 after the second pulse
    rx_thresh_i = 8'd8; rx_timeout_i = 16'd20;
    evt_i = 9'h002; tick();
    evt_i = '0; tick(); tick();
    evt_i = 9'h002; tick();
    evt_i = '0;
    for (int i = 0; i < 19; i++) tick();
    chk("tmo_early", 32'(status_o[1]), 32'h0);
    tick();
    chk("tmo_fire", 32'(status_o[1]), 32'h1);
    chk("tmo_cnt0", 32'(rx_cnt_o), 32'h0);
    clear_all();

    // async reset in the middle of accumulation
    enable_i = 9'h100; evt_i = 9'h100; tick();
    evt_i = '0; tick();
    rx_thresh_i = 8'd8; rx_timeout_i = '0;
    for (int p = 0; p < 3; p++) begin
      evt_i = 9'h002; tick();
      evt_i = '0; tick();
    end
    chk("accum_cnt3", 32'(rx_cnt_o), 32'h3);
    chk("accum_irq", 32'(irq_o), 32'h1);
    #2 rstn_i = 1'b0;
    #1;
    chk("async_status", 32'(status_o), 32'h0);
    chk("async_irq", 32'(irq_o), 32'h0);
    chk("async_cnt", 32'(rx_cnt_o), 32'h0);
    chk("async_pending", 32'(pending_o), 32'h0);
    model_reset();
    #3 rstn_i = 1'b1;
    rx_thresh_i = 8'd2; rx_timeout_i = 16'd5;
    for (int i = 0; i < 30; i++) tick();
    chk("post_rst_nofire", 32'(status_o[1]), 32'h0);
    chk("post_rst_cnt", 32'(rx_cnt_o), 32'h0);

    // randomized traffic, thresholds and timeouts changing on the fly
    for (int i = 0; i < 1500; i++) begin
      if (i % 40 == 0) begin
        rx_thresh_i  = 8'($urandom_range(0, 5));
        rx_timeout_i = 16'($urandom_range(0, 8));
      end
      evt_i       = 9'($urandom) & 9'($urandom) & 9'($urandom);
      evt_i[1]    = ($urandom_range(0, 3) == 0);
      if (i % 16 == 0) enable_i = 9'($urandom);
      clr_we_i    = ($urandom_range(0, 4) == 0);
      clr_data_i  = 9'($urandom);
      set_we_i    = ($urandom_range(0, 9) == 0);
      set_data_i  = 9'($urandom) & 9'($urandom);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
